adj_key_ctrl: RTL



---
 rtl/adj_key_ctrl.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/adj_key_ctrl.sv
// Front-panel adjust controller: debounced MODE/UP/DOWN keys drive per-stage digit selects and shared up/down pulses.
// Optional auto-repeat of held UP/DOWN keys is built when ADJ_AUTO_REPEAT_EN is defined.
module adj_key_ctrl #(
    parameter int          PAR_NUM_FIELDS = 3,
    parameter logic [19:0] PAR_DEB_CYCLES = 20'd500000,
    parameter logic [23:0] PAR_REP_DELAY  = 24'd10000000,
    parameter logic [23:0] PAR_REP_PERIOD = 24'd2500000
) (
    input  logic                          I_SYS_CLK,
    input  logic                          I_EXT_RST,
    input  logic                          I_KEY_MODE,
    input  logic                          I_KEY_UP,
    input  logic                          I_KEY_DOWN,
    output logic                          O_ADJ_UP,
    output logic                          O_ADJ_DOWN,
    output logic [2*PAR_NUM_FIELDS-1:0]   O_ADJ_SEL,
    output logic                          O_ADJ_ACTIVE
);

    localparam int K_MODE = 0;
    localparam int K_UP   = 1;
    localparam int K_DN   = 2;
    localparam int POS_W  = $clog2(2 * PAR_NUM_FIELDS + 1);
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(2 * PAR_NUM_FIELDS);
    localparam int SEL_W = 2 * PAR_NUM_FIELDS;

    // Odd positions select digit A (pair 10), even positions digit B (pair 01) of stage (p-1)>>1.
    function automatic logic [SEL_W-1:0] sel_encode(input logic [POS_W-1:0] p);
        logic [POS_W-1:0] pm1;
        pm1 = p - POS_ONE;
        sel_encode = '1;
        for (int f = 0; f < PAR_NUM_FIELDS; f++) begin
            if ((p != '0) && (pm1[POS_W-1:1] == f[POS_W-2:0])) begin
                sel_encode[2*f +: 2] = p[0] ? 2'b10 : 2'b01;
            end else begin
                sel_encode[2*f +: 2] = 2'b11;
            end
        end
    endfunction

    logic [2:0]        raw_s;
    logic [2:0]        sync1_q;
    logic [2:0]        sync2_q;
    logic [2:0]        deb_q;
    logic [2:0]        deb_d;
    logic [2:0]        deb_prev_q;
    logic [2:0]        rise_s;
    logic [2:0][19:0]  cnt_q;
    logic [2:0][19:0]  cnt_d;

    logic [POS_W-1:0]  pos_q;
    logic [POS_W-1:0]  pos_d;
    logic [SEL_W-1:0]  sel_q;
    logic [SEL_W-1:0]  sel_d;
    logic              act_q;
    logic              act_d;
    logic              up_q;
    logic              up_d;
    logic              dn_q;
    logic              dn_d;

    logic              mode_ev_s;
    logic              up_ev_s;
    logic              dn_ev_s;
    logic              both_s;
    logic              edit_s;
    logic              press_up_s;
    logic              press_dn_s;

    assign raw_s     = {I_KEY_DOWN, I_KEY_UP, I_KEY_MODE};
    assign rise_s    = deb_q & ~deb_prev_q;
    assign mode_ev_s = rise_s[K_MODE];
    assign up_ev_s   = rise_s[K_UP];
    assign dn_ev_s   = rise_s[K_DN];
    assign both_s    = deb_q[K_UP] & deb_q[K_DN];
    assign edit_s    = (pos_q != '0);

    // Debouncer next state: count consecutive cycles where the synchronized level disagrees.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int k = 0; k < 3; k++) begin
            if (sync2_q[k] == deb_q[k]) begin
                cnt_d[k] = 20'd0;
            end else if (cnt_q[k] == (PAR_DEB_CYCLES - 20'd1)) begin
                cnt_d[k] = 20'd0;
                deb_d[k] = sync2_q[k];
            end else begin
                cnt_d[k] = cnt_q[k] + 20'd1;
            end
        end
    end

    // Position stepping and initial key pulses; MODE suppresses a same-cycle UP/DOWN press.
    always_comb begin
        pos_d      = pos_q;
        press_up_s = 1'b0;
        press_dn_s = 1'b0;
        if (mode_ev_s) begin
            if (pos_q == POS_LAST) begin
                pos_d = '0;
            end else begin
                pos_d = pos_q + POS_ONE;
            end
        end else if (edit_s && !both_s) begin
            press_up_s = up_ev_s;
            press_dn_s = dn_ev_s & ~up_ev_s;
        end else begin
            pos_d = pos_q;
        end
    end

`ifdef ADJ_AUTO_REPEAT_EN
    logic        rep_act_q;
    logic        rep_act_d;
    logic        rep_dir_q;
    logic        rep_dir_d;
    logic        rep_ph_q;
    logic        rep_ph_d;
    logic [23:0] rep_cnt_q;
    logic [23:0] rep_cnt_d;
    logic [23:0] rep_lim_s;
    logic        rep_held_s;
    logic        rep_up_s;
    logic        rep_dn_s;

    assign rep_lim_s  = rep_ph_q ? (PAR_REP_PERIOD - 24'd1) : (PAR_REP_DELAY - 24'd1);
    assign rep_held_s = rep_dir_q ? deb_q[K_UP] : deb_q[K_DN];

    // Repeat timer: armed by an initial pulse, first waits the delay, then fires every period.
    always_comb begin
        rep_act_d = rep_act_q;
        rep_dir_d = rep_dir_q;
        rep_ph_d  = rep_ph_q;
        rep_cnt_d = rep_cnt_q;
        rep_up_s  = 1'b0;
        rep_dn_s  = 1'b0;
        if (mode_ev_s || !edit_s || both_s) begin
            rep_act_d = 1'b0;
            rep_ph_d  = 1'b0;
            rep_cnt_d = 24'd0;
        end else if (press_up_s || press_dn_s) begin
            rep_act_d = 1'b1;
            rep_dir_d = press_up_s;
            rep_ph_d  = 1'b0;
            rep_cnt_d = 24'd0;
        end else if (rep_act_q && rep_held_s) begin
            if (rep_cnt_q == rep_lim_s) begin
                rep_cnt_d = 24'd0;
                rep_ph_d  = 1'b1;
                rep_up_s  = rep_dir_q;
                rep_dn_s  = ~rep_dir_q;
            end else begin
                rep_cnt_d = rep_cnt_q + 24'd1;
            end
        end else begin
            rep_act_d = 1'b0;
            rep_ph_d  = 1'b0;
            rep_cnt_d = 24'd0;
        end
    end

    // Repeat timer state register.
    always_ff @(posedge I_SYS_CLK) begin
        if (I_EXT_RST) begin
            rep_act_q <= 1'b0;
            rep_dir_q <= 1'b0;
            rep_ph_q  <= 1'b0;
            rep_cnt_q <= 24'd0;
        end else begin
            rep_act_q <= rep_act_d;
            rep_dir_q <= rep_dir_d;
            rep_ph_q  <= rep_ph_d;
            rep_cnt_q <= rep_cnt_d;
        end
    end

    assign up_d = press_up_s | rep_up_s;
    assign dn_d = press_dn_s | rep_dn_s;
`else
    logic unused_rep_cfg_s;
    assign unused_rep_cfg_s = ^{PAR_REP_DELAY, PAR_REP_PERIOD};

    assign up_d = press_up_s;
    assign dn_d = press_dn_s;
`endif

    assign sel_d = sel_encode(pos_d);
    assign act_d = (pos_d != '0);

    // Synchronizers, debouncers, position and registered outputs.
    always_ff @(posedge I_SYS_CLK) begin
        if (I_EXT_RST) begin
            sync1_q    <= 3'b000;
            sync2_q    <= 3'b000;
            deb_q      <= 3'b000;
            deb_prev_q <= 3'b000;
            cnt_q      <= '0;
            pos_q      <= '0;
            sel_q      <= '1;
            act_q      <= 1'b0;
            up_q       <= 1'b0;
            dn_q       <= 1'b0;
        end else begin
            sync1_q    <= raw_s;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            sel_q      <= sel_d;
            act_q      <= act_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
        end
    end

    assign O_ADJ_UP     = up_q;
    assign O_ADJ_DOWN   = dn_q;
    assign O_ADJ_SEL    = sel_q;
    assign O_ADJ_ACTIVE = act_q;

endmodule
